// File: rtl/msix_pkg.sv
// Shared types and helpers for the MSI-X Pending Bit Array controller.
package msix_pkg;

    // Message FSM: IDLE picks a winner, SEND holds it until accepted.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } msix_state_e;

    // Field positions inside the PBA Offset/BIR register.
    localparam int unsigned PBA_BIR_LSB    = 0;
    localparam int unsigned PBA_BIR_MSB    = 2;
    localparam int unsigned PBA_OFFSET_LSB = 3;

    // Vector index width; at least one bit even for a single vector.
    function automatic int unsigned vec_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The PBA occupies whole QWORDs, so the DWORD count is always even.
    function automatic int unsigned pba_dwords(int unsigned n);
        return 2 * ((n + 63) / 64);
    endfunction

endpackage

// File: rtl/msix_pba_controller_if.sv
// Message-request stream and PBA read port of the MSI-X PBA controller.
// master: the controller (sources messages, answers reads); slave: its peers.
interface msix_pba_controller_if
    import msix_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 32,
    parameter int unsigned ADDR_W      = 32
);
    localparam int unsigned VecW = vec_w(NUM_VECTORS);

    logic              msg_valid;
    logic              msg_ready;
    logic [VecW-1:0]   msg_vector;
    logic              rd_valid;
    logic [2:0]        rd_bar;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data_valid;
    logic              rd_hit;
    logic [31:0]       rd_data;

    modport master (
        output msg_valid, msg_vector, rd_data_valid, rd_hit, rd_data,
        input  msg_ready, rd_valid, rd_bar, rd_addr
    );

    modport slave (
        input  msg_valid, msg_vector, rd_data_valid, rd_hit, rd_data,
        output msg_ready, rd_valid, rd_bar, rd_addr
    );

endinterface

// File: rtl/msix_vector_arbiter.sv
// Picks one eligible MSI-X vector.
// MSIX_PBA_RR_ARB_EN defined: round-robin starting at ptr_i.
// Undefined: fixed priority, lowest index wins, ptr_i ignored.
module msix_vector_arbiter #(
    parameter int unsigned NUM_VECTORS = 32,
    parameter int unsigned VEC_W       = 5
) (
    input  logic [NUM_VECTORS-1:0] eligible_i,
    input  logic [VEC_W-1:0]       ptr_i,
    output logic [VEC_W-1:0]       winner_o,
    output logic                   any_valid_o
);

    assign any_valid_o = |eligible_i;

`ifdef MSIX_PBA_RR_ARB_EN
    logic [VEC_W-1:0] hi_winner;
    logic [VEC_W-1:0] lo_winner;
    logic             hi_valid;

    // Lowest eligible at/above the pointer, else wrap to lowest eligible overall.
    always_comb begin
        hi_winner = '0;
        lo_winner = '0;
        hi_valid  = 1'b0;
        for (int i = int'(NUM_VECTORS) - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                lo_winner = VEC_W'(i);
                if (VEC_W'(i) >= ptr_i) begin
                    hi_winner = VEC_W'(i);
                    hi_valid  = 1'b1;
                end
            end
        end
        winner_o = hi_valid ? hi_winner : lo_winner;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Fixed priority: descending scan leaves the lowest eligible index.
    always_comb begin
        winner_o = '0;
        for (int i = int'(NUM_VECTORS) - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                winner_o = VEC_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/msix_pba_controller.sv
// MSI-X Pending Bit Array: latches interrupt requests, arbitrates unmasked
// pending vectors into a valid/ready message stream and answers DWORD reads
// that fall into the PBA window selected by pba_offset_bir.
// Optional: MSIX_PBA_RR_ARB_EN selects round-robin arbitration (default fixed).
module msix_pba_controller
    import msix_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 32,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            pba_offset_bir,
    input  logic                   msix_enable,
    input  logic                   function_mask,
    input  logic [NUM_VECTORS-1:0] vector_mask,
    input  logic [NUM_VECTORS-1:0] int_req,
    msix_pba_controller_if.master  bus,
    output logic [NUM_VECTORS-1:0] pending
);

    localparam int unsigned VecW    = vec_w(NUM_VECTORS);
    localparam int unsigned PbaDw   = pba_dwords(NUM_VECTORS);
    localparam int unsigned PbaBits = 32 * PbaDw;
    localparam int unsigned DwW     = (PbaDw > 1) ? $clog2(PbaDw) : 1;

    msix_state_e            state_q, state_d;
    logic [VecW-1:0]        msg_vector_q, msg_vector_d;
    logic [NUM_VECTORS-1:0] pending_q, pending_d;
    logic                   rd_data_valid_q, rd_data_valid_d;
    logic                   rd_hit_q, rd_hit_d;
    logic [31:0]            rd_data_q, rd_data_d;

    logic [NUM_VECTORS-1:0] eligible;
    logic                   any_valid;
    logic [VecW-1:0]        winner;
    logic [VecW-1:0]        rr_ptr;
    logic                   accept;

    logic [31:0]            base32;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W-1:0]      dw_off;
    logic [DwW-1:0]         dw_idx;
    logic [PbaBits-1:0]     pba_ext;

    assign accept   = (state_q == SEND) & bus.msg_ready;
    assign eligible = pending_q & ~vector_mask & {NUM_VECTORS{~function_mask & msix_enable}};

    msix_vector_arbiter #(
        .NUM_VECTORS (NUM_VECTORS),
        .VEC_W       (VecW)
    ) u_arbiter (
        .eligible_i  (eligible),
        .ptr_i       (rr_ptr),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

`ifdef MSIX_PBA_RR_ARB_EN
    logic [VecW-1:0] ptr_q, ptr_d;

    // Pointer moves just past the vector that was accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && msix_enable) begin
            ptr_d = (msg_vector_q == VecW'(NUM_VECTORS - 1)) ? '0 : msg_vector_q + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign rr_ptr = ptr_q;
`else
    assign rr_ptr = '0;
`endif

    // Message FSM; disabling MSI-X aborts any held request.
    always_comb begin
        state_d      = state_q;
        msg_vector_d = msg_vector_q;
        if (!msix_enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        state_d      = SEND;
                        msg_vector_d = winner;
                    end
                end
                SEND: begin
                    if (bus.msg_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pending bits: clear on accept, then set, so a same-cycle request wins.
    always_comb begin
        pending_d = pending_q;
        if (accept) pending_d[msg_vector_q] = 1'b0;
        pending_d = pending_d | int_req;
        if (!msix_enable) pending_d = '0;
    end

    // PBA window decode and DWORD select on the current pending contents.
    always_comb begin
        base32          = {pba_offset_bir[31:PBA_OFFSET_LSB], 3'b000};
        base            = ADDR_W'(base32);
        dw_off          = (bus.rd_addr - base) >> 2;
        dw_idx          = dw_off[DwW-1:0];
        pba_ext         = PbaBits'(pending_q);
        rd_data_valid_d = bus.rd_valid;
        rd_hit_d        = bus.rd_valid
                        & (bus.rd_bar == pba_offset_bir[PBA_BIR_MSB:PBA_BIR_LSB])
                        & (bus.rd_addr >= base)
                        & (dw_off < ADDR_W'(PbaDw));
        rd_data_d       = rd_hit_d ? pba_ext[{dw_idx, 5'b00000} +: 32] : 32'h0;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            msg_vector_q    <= '0;
            pending_q       <= '0;
            rd_data_valid_q <= 1'b0;
            rd_hit_q        <= 1'b0;
            rd_data_q       <= 32'h0;
        end else begin
            state_q         <= state_d;
            msg_vector_q    <= msg_vector_d;
            pending_q       <= pending_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_hit_q        <= rd_hit_d;
            rd_data_q       <= rd_data_d;
        end
    end

    assign bus.msg_valid     = (state_q == SEND);
    assign bus.msg_vector    = msg_vector_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.rd_hit        = rd_hit_q;
    assign bus.rd_data       = rd_data_q;
    assign pending           = pending_q;

endmodule

// File: doc/msix_pba_controller.md
Name: msix_pba_controller

Overview:
Downstream consumer of the PBA Offset/BIR register in the MSI-X capability. It holds the Pending Bit Array for NUM_VECTORS vectors and sets bits on interrupt requests. It arbitrates unmasked pending vectors into a valid/ready message-request stream toward the MSI-X message generator. It also answers DWORD memory reads that decode into the PBA window selected by pba_offset_bir.

Parameters:
NUM_VECTORS, 32, implemented MSI-X vectors (1..64)
ADDR_W, 32, BAR-relative read address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
pba_offset_bir  in  32  from PBA register; [31:3] QWORD-aligned offset, [2:0] BIR
msix_enable  in  1  MSI-X Enable
function_mask  in  1  MSI-X Function Mask
vector_mask  in  NUM_VECTORS  per-vector Mask bits from the MSI-X table
int_req  in  NUM_VECTORS  one-cycle interrupt request pulses
msg_valid  out  1  message request valid
msg_ready  in  1  message generator accepts
msg_vector  out  VEC_W  vector index, VEC_W = max(1,clog2(NUM_VECTORS))
rd_valid  in  1  memory read request, one cycle
rd_bar  in  3  BAR number of the read
rd_addr  in  ADDR_W  BAR-relative byte address, DWORD aligned
rd_data_valid  out  1  read response strobe
rd_hit  out  1  read decoded into PBA
rd_data  out  32  read data
pending  out  NUM_VECTORS  current PBA contents

Behaviour:
- Reset: pending=0, state IDLE, msg_valid=0, msg_vector=0, rd_data_valid=0, rd_hit=0, rd_data=0, RR pointer=0.
- Set: int_req[i]=1 with msix_enable=1 sets pending[i] at the next edge. int_req is ignored while msix_enable=0.
- Eligible vector: pending[i] & ~vector_mask[i] & ~function_mask & msix_enable.
- FSM IDLE: if any vector is eligible, latch the arbiter winner into msg_vector, set msg_valid=1, go to SEND. The first msg_valid appears 1 cycle after the pending bit registers.
- FSM SEND: msg_valid and msg_vector stay stable until msg_ready. On msg_valid&msg_ready, clear pending[msg_vector], deassert msg_valid, return to IDLE. This gives a minimum 1-cycle gap between messages.
- A mask set during SEND does not withdraw the request. Masking is checked only at the IDLE selection point.
- A new int_req on the same vector in the accept cycle: set wins, so pending stays 1 and a later message is sent.
- msix_enable falling, in any state: at the next edge all pending bits clear, msg_valid=0, state IDLE. The stable-valid rule is waived for this case only.
- Read decode: base = {pba_offset_bir[31:3],3'b000}, truncated to ADDR_W. Hit = rd_valid & (rd_bar==pba_offset_bir[2:0]) & (rd_addr>=base) & ((rd_addr-base)>>2 < 2*ceil(NUM_VECTORS/64)).
- DWORD index d = (rd_addr-base)>>2. rd_data = pending[32d+31:32d]; bits at or above NUM_VECTORS read 0.
- Read response: registered, rd_data_valid exactly 1 cycle after rd_valid. On a miss: rd_hit=0, rd_data=0.
- Read data reflects pending as it stood in the rd_valid cycle.
- The PBA is read-only; no write path exists.
- Reset mid-operation: asynchronous return to the reset values. Any in-flight message or read response is dropped.

Optional Feature:
MSIX_PBA_RR_ARB_EN
- Defined: round-robin arbitration. The search starts at pointer, and after each accept the pointer becomes msg_vector+1 (mod NUM_VECTORS).
- Undefined: fixed priority, lowest eligible index wins; the pointer logic is absent.

Decomposition:
- Package msix_pkg holds: FSM state enum (IDLE, SEND); VEC_W helper function; PBA_DWORDS(n) = 2*ceil(n/64); PBA_BIR_LSB/MSB and PBA_OFFSET_LSB field constants.
- Sub-module msix_vector_arbiter: eligible vector in, pointer in, winner index and any_valid out. It contains the MSIX_PBA_RR_ARB_EN selection.

Test Plan:
1. msix_enable=1, int_req[5] pulse, msg_ready=1 -> msg_valid 1 cycle after pending[5]=1; msg_vector=5; pending[5]=0 after accept.
2. vector_mask[3]=1, int_req[3] -> pending[3]=1, no msg_valid. Clear mask -> message for vector 3 follows.
3. int_req bits 2 and 7 together, RR build, pointer=3 -> vector 7 sent first, then 2. Fixed-priority build -> 2 then 7.
4. pba_offset_bir=32'h0000_2002, NUM_VECTORS=40, pending=40'h80_0000_0001:
   - rd_bar=2, rd_addr=0x2000 -> rd_hit=1, rd_data=32'h0000_0001.
   - rd_addr=0x2004 -> rd_data=32'h0000_0080.
   - rd_addr=0x2010 -> rd_hit=0.
   - rd_bar=1 -> rd_hit=0.
5. In SEND with msg_ready=0, int_req on the same vector in the accept cycle -> pending stays 1 and a second message follows. msix_enable drop -> pending=0, msg_valid=0 next cycle.
6. reset_n asserted low mid-SEND, asynchronous to clk -> msg_valid=0 and pending=0 immediately, no message after release.
